// File: rtl/parity_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parity_pkg                                                            |
// | Shared constants and helpers for the parity generator/checker pair.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package parity_pkg;

    localparam int c_data_w = 32;

    typedef logic [c_data_w-1:0] word_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input word_t d);
        return ^d;
    endfunction

    // Increment that sticks at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] lim;
        if (w >= 32) begin
            lim = '1;
        end else begin
            lim = (32'h1 << w) - 32'h1;
        end
        return (v >= lim) ? lim : v + 32'h1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/parity_reduce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parity_reduce                                                         |
// | Combinational XOR reduction of a WIDTH-bit word.                      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module parity_reduce
    import parity_pkg::*;
#(
    parameter int WIDTH = c_data_w
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    generate
        if (WIDTH == c_data_w) begin : g_pkg_fn
            assign parity = even_parity(data);
        end else begin : g_generic
            assign parity = ^data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/parity_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parity_checker                                                        |
// | Receive-side parity check with a one-deep valid/ready output stage,   |
// | saturating error counter and sticky error flag.                       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_W   = c_data_w,
    parameter int CNT_W    = 16,
    parameter int DROP_ERR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    input  logic              clr_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_sticky
);

    logic              w_calc_parity;
    logic              w_acc;
    logic              w_bad;
    logic              w_drop;
    logic [CNT_W-1:0]  w_cnt_inc;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_perr;
    logic [CNT_W-1:0]  r_err_cnt;
    logic              r_err_sticky;

    parity_reduce #(
        .WIDTH (DATA_W)
    ) u_reduce (
        .data   (in_data),
        .parity (w_calc_parity)
    );

    assign in_ready  = !r_out_valid || out_ready;
    assign w_acc     = in_valid && in_ready;
    // Gating with w_acc keeps an undriven in_parity out of the counter.
    assign w_bad     = w_acc && (w_calc_parity != in_parity);
    assign w_drop    = (DROP_ERR != 0) && w_bad;
    assign w_cnt_inc = CNT_W'(sat_inc(32'(r_err_cnt), CNT_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_perr  <= 1'b0;
        end else if (w_acc && !w_drop) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
            r_out_perr  <= w_bad;
        end else if (out_ready) begin
            // Also covers a dropped word: accepting implies the slot drains.
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt    <= '0;
            r_err_sticky <= 1'b0;
        end else if (clr_err) begin
            r_err_cnt    <= w_bad ? CNT_W'(1) : '0;
            r_err_sticky <= w_bad;
        end else if (w_bad) begin
            r_err_cnt    <= w_cnt_inc;
            r_err_sticky <= 1'b1;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_perr   = r_out_perr;
    assign err_cnt    = r_err_cnt;
    assign err_sticky = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_parity_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_parity_checker                                                     |
// | Two checker instances (forward / drop with 3-bit counter) vs a model. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_parity_checker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_parity;
    logic        out_ready;
    logic        clr_err;

    logic        in_ready0, out_valid0, out_perr0, err_sticky0;
    logic [31:0] out_data0;
    logic [15:0] err_cnt0;
    logic        in_ready1, out_valid1, out_perr1, err_sticky1;
    logic [31:0] out_data1;
    logic [2:0]  err_cnt1;

    int ncmp  = 0;
    int nfail = 0;

    // Reference: a one-entry slot plus counter, indexed by instance.
    bit          mv [2];
    logic [31:0] md [2];
    bit          mp [2];
    int          mc [2];
    bit          ms [2];
    int          cmax [2] = '{65535, 7};
    bit          drop [2] = '{1'b0, 1'b1};

    parity_checker #(.DATA_W(32), .CNT_W(16), .DROP_ERR(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_parity(in_parity), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .out_perr(out_perr0),
        .clr_err(clr_err), .err_cnt(err_cnt0), .err_sticky(err_sticky0)
    );

    parity_checker #(.DATA_W(32), .CNT_W(3), .DROP_ERR(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_parity(in_parity), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(out_data1), .out_perr(out_perr1),
        .clr_err(clr_err), .err_cnt(err_cnt1), .err_sticky(err_sticky1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_par(input logic [31:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    function automatic logic [51:0] obs(input int k);
        if (k == 0) return {in_ready0, out_valid0, out_data0, out_perr0, err_cnt0, err_sticky0};
        return {in_ready1, out_valid1, out_data1, out_perr1, 13'b0, err_cnt1, err_sticky1};
    endfunction

    function automatic logic [51:0] expv(input int k);
        logic rdy;
        rdy = !mv[k] || out_ready;
        return {rdy, mv[k], md[k], mp[k], 16'(mc[k]), ms[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mv[k] = 0; md[k] = '0; mp[k] = 0; mc[k] = 0; ms[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit acc, bad;
            acc = in_valid && (!mv[k] || out_ready);
            bad = acc && (ref_par(in_data) != in_parity);
            if (clr_err) begin
                mc[k] = bad ? 1 : 0;
                ms[k] = bad;
            end else if (bad) begin
                if (mc[k] < cmax[k]) mc[k] = mc[k] + 1;
                ms[k] = 1;
            end
            if (acc && !(drop[k] && bad)) begin
                mv[k] = 1; md[k] = in_data; mp[k] = bad;
            end else if (out_ready) begin
                mv[k] = 0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input bit p,
                         input bit r, input bit c);
        in_valid = v; in_data = d; in_parity = p; out_ready = r; clr_err = c;
    endtask

    task automatic test_reset();
        rst_n = 0;
        drive(0, '0, 0, 1, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            ncmp++;
            if (obs(k) !== {1'b1, 51'b0}) begin
                nfail++;
                $display("FAIL reset dut%0d got=%h exp=%h", k, obs(k), {1'b1, 51'b0});
            end
        end
        tick();
    endtask

    task automatic test_stream();
        logic [31:0] w [4] = '{32'h3456_789a, 32'hc4c6_78ff, 32'hff56_ff9a, 32'h3faa_aaaa};
        bit          p [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) drive(1, w[i], p[i], 1, 0);
            else       drive(0, '0, 0, 1, 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                ncmp++;
                if (obs(k) !== expv(k)) begin
                    nfail++;
                    $display("FAIL stream[%0d] dut%0d got=%h exp=%h", i, k, obs(k), expv(k));
                end
            end
            if (i > 0) begin
                ncmp++;
                if (out_valid0 !== 1'b1 || out_data0 !== w[i-1] || out_perr0 !== 1'b0 || err_cnt0 !== 16'd0) begin
                    nfail++;
                    $display("FAIL stream_word[%0d] got v=%b d=%h perr=%b cnt=%0d exp v=1 d=%h perr=0 cnt=0",
                             i - 1, out_valid0, out_data0, out_perr0, err_cnt0, w[i-1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_bad_word();
        drive(1, 32'hff56_ff9a, 1, 1, 0);
        #1;
        tick();
        drive(1, 32'h3456_789a, 1, 1, 0);
        #1;
        ncmp++;
        if (out_valid0 !== 1'b1 || out_perr0 !== 1'b1 || err_cnt0 !== 16'd1 || err_sticky0 !== 1'b1) begin
            nfail++;
            $display("FAIL bad_fwd got v=%b perr=%b cnt=%0d sticky=%b exp v=1 perr=1 cnt=1 sticky=1",
                     out_valid0, out_perr0, err_cnt0, err_sticky0);
        end
        ncmp++;
        if (out_valid1 !== 1'b0 || err_cnt1 !== 3'd1 || err_sticky1 !== 1'b1) begin
            nfail++;
            $display("FAIL bad_drop got v=%b cnt=%0d sticky=%b exp v=0 cnt=1 sticky=1",
                     out_valid1, err_cnt1, err_sticky1);
        end
        tick();
        drive(0, '0, 0, 1, 0);
        #1;
        ncmp++;
        if (out_valid1 !== 1'b1 || out_data1 !== 32'h3456_789a || out_perr1 !== 1'b0) begin
            nfail++;
            $display("FAIL drop_next_good got v=%b d=%h perr=%b exp v=1 d=3456789a perr=0",
                     out_valid1, out_data1, out_perr1);
        end
        for (int k = 0; k < 2; k++) begin
            ncmp++;
            if (obs(k) !== expv(k)) begin
                nfail++;
                $display("FAIL bad_model dut%0d got=%h exp=%h", k, obs(k), expv(k));
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, c;
        a = $urandom;
        c = $urandom;
        drive(1, a, ref_par(a), 1, 0);
        #1;
        tick();
        for (int i = 0; i < 5; i++) begin
            b = $urandom;
            drive(1, b, ref_par(b), 0, 0);
            #1;
            ncmp++;
            if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1 || out_data0 !== a) begin
                nfail++;
                $display("FAIL hold[%0d] got rdy=%b v=%b d=%h exp rdy=0 v=1 d=%h",
                         i, in_ready0, out_valid0, out_data0, a);
            end
            for (int k = 0; k < 2; k++) begin
                ncmp++;
                if (obs(k) !== expv(k)) begin
                    nfail++;
                    $display("FAIL hold_model[%0d] dut%0d got=%h exp=%h", i, k, obs(k), expv(k));
                end
            end
            tick();
        end
        drive(1, c, ref_par(c), 1, 0);
        #1;
        ncmp++;
        if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin
            nfail++;
            $display("FAIL release_ready got %b/%b exp 1/1", in_ready0, in_ready1);
        end
        tick();
        drive(0, '0, 0, 1, 0);
        #1;
        ncmp++;
        if (out_valid0 !== 1'b1 || out_data0 !== c || out_data1 !== c) begin
            nfail++;
            $display("FAIL release_word got v=%b d=%h/%h exp v=1 d=%h", out_valid0, out_data0, out_data1, c);
        end
        tick();
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        drive(0, '0, 0, 1, 1);
        #1;
        tick();
        for (int i = 0; i < 10; i++) begin
            d = $urandom;
            drive(1, d, !ref_par(d), 1, 0);
            #1;
            tick();
        end
        drive(0, '0, 0, 1, 0);
        #1;
        ncmp++;
        if (err_cnt1 !== 3'd7 || err_cnt0 !== 16'd10) begin
            nfail++;
            $display("FAIL saturate got cnt1=%0d cnt0=%0d exp cnt1=7 cnt0=10", err_cnt1, err_cnt0);
        end
        tick();
        d = $urandom;
        drive(1, d, !ref_par(d), 1, 1);
        #1;
        tick();
        drive(0, '0, 0, 1, 0);
        #1;
        ncmp++;
        if (err_cnt0 !== 16'd1 || err_cnt1 !== 3'd1 || err_sticky0 !== 1'b1 || err_sticky1 !== 1'b1) begin
            nfail++;
            $display("FAIL clr_with_bad got cnt=%0d/%0d sticky=%b/%b exp 1/1 1/1",
                     err_cnt0, err_cnt1, err_sticky0, err_sticky1);
        end
        tick();
        drive(0, '0, 0, 1, 1);
        #1;
        tick();
        drive(0, '0, 0, 1, 0);
        #1;
        ncmp++;
        if (err_cnt0 !== 16'd0 || err_cnt1 !== 3'd0 || err_sticky0 !== 1'b0 || err_sticky1 !== 1'b0) begin
            nfail++;
            $display("FAIL clr_alone got cnt=%0d/%0d sticky=%b/%b exp 0/0 0/0",
                     err_cnt0, err_cnt1, err_sticky0, err_sticky1);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] d;
        for (int i = 0; i < 400; i++) begin
            d = $urandom;
            drive(($urandom % 4) != 0, d, ref_par(d) ^ (($urandom % 6) == 0),
                  ($urandom % 3) != 0, ($urandom % 50) == 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                ncmp++;
                if (obs(k) !== expv(k)) begin
                    nfail++;
                    $display("FAIL random[%0d] dut%0d got=%h exp=%h", i, k, obs(k), expv(k));
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        d = $urandom;
        drive(1, d, !ref_par(d), 1, 0);
        #1;
        tick();
        d = $urandom;
        drive(1, d, ref_par(d), 0, 0);
        #1;
        tick();
        #2 rst_n = 0;
        model_reset();
        #1;
        ncmp++;
        if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || err_cnt0 !== 16'd0 || err_sticky0 !== 1'b0) begin
            nfail++;
            $display("FAIL async_reset got v=%b/%b cnt=%0d sticky=%b exp v=0/0 cnt=0 sticky=0",
                     out_valid0, out_valid1, err_cnt0, err_sticky0);
        end
        for (int k = 0; k < 2; k++) begin
            ncmp++;
            if (obs(k) !== expv(k)) begin
                nfail++;
                $display("FAIL async_model dut%0d got=%h exp=%h", k, obs(k), expv(k));
            end
        end
        @(posedge clk);
        #1 rst_n = 1;
        drive(0, '0, 0, 1, 0);
        #1;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_bad_word();
        test_backpressure();
        test_saturation();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
